// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the multicycle units built around it.
//   ALU_ADD / ALU_SLT / ALU_OR : opcodes understood by alu_32bit
//   state_t                    : control states of the sequential multiplier
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_32bit.sv
// Purely combinational 32-bit ALU.
//   a, b   : operands
//   Aluop  : operation select (ALU_ADD, ALU_SLT, ALU_OR; anything else yields 0)
//   cin    : carry-in, used by ADD only
//   R      : result
//   S      : sign of the result (R[31])
//   V      : signed overflow of ADD
//   cout   : carry-out of ADD
module alu_32bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  Aluop,
  input  logic        cin,
  output logic [31:0] R,
  output logic        S,
  output logic        V,
  output logic        cout
);

  logic [32:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {32'b0, cin};

  always_comb begin
    R    = '0;
    V    = 1'b0;
    cout = 1'b0;
    case (Aluop)
      ALU_ADD: begin
        R    = sum[31:0];
        cout = sum[32];
        // Overflow when both operands share a sign the result does not.
        V    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SLT: R = {31'b0, ($signed(a) < $signed(b))};
      ALU_OR:  R = a | b;
      default: R = '0;
    endcase
    S = R[31];
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned shift-add multiplier, one ALU addition per cycle.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, discards any operation in flight
//   start   : request; only looked at while idle
//   a, b    : multiplicand / multiplier, captured when start is accepted
//   busy    : high during the 32 iteration cycles
//   done    : one-cycle pulse when product becomes valid
//   product : a*b, held until the next completed multiply
module mult32_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32  // the ALU instance fixes this at 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  // acc = {carry, hi, lo}; lo starts as the multiplier and is shifted out
  // one bit per iteration while partial sums shift in from hi.
  logic [2*WIDTH:0]     acc_reg, acc_next;
  logic [5:0]           cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;

  logic [WIDTH-1:0]     alu_r;
  logic                 alu_cout;
  logic                 alu_s;
  logic                 alu_v;
  logic                 unused_alu_flags;

  assign unused_alu_flags = alu_s ^ alu_v;

  alu_32bit u_alu (
    .a     (acc_reg[2*WIDTH-1:WIDTH]),
    .b     (mcand_reg),
    .Aluop (ALU_ADD),
    .cin   (1'b0),
    .R     (alu_r),
    .S     (alu_s),
    .V     (alu_v),
    .cout  (alu_cout)
  );

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mcand_next = a;
          acc_next   = {1'b0, {WIDTH{1'b0}}, b};
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // The ALU carry becomes the top bit of the shifted accumulator, so
        // hi+mcand never loses its 33rd bit.
        if (acc_reg[0]) begin
          acc_next = {alu_cout, alu_r, acc_reg[WIDTH-1:1]};
        end else begin
          acc_next = {1'b0, acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1:1]};
        end
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'(WIDTH - 1)) begin
          state_next   = ST_DONE;
          // Capture the final accumulator on entry to DONE so product is
          // already valid in the same cycle that done pulses.
          product_next = acc_next[2*WIDTH-1:0];
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign busy    = (state_reg == ST_RUN);
  assign done    = (state_reg == ST_DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed cases plus randomized traffic
// against a timeline model (operation accepted -> 32 busy cycles -> one done
// cycle -> one idle cycle) with the product computed by plain multiplication.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int pass_cnt = 0;
  int total_cnt = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Reference model: cycles elapsed since the accepting edge (-1 = free).
  // Cycles 1..32 are busy, cycle 33 shows done and the new product.
  int          since = -1;
  logic [63:0] pending = '0;
  logic [63:0] exp_product = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since       <= -1;
      pending     <= '0;
      exp_product <= '0;
    end else if (since < 0) begin
      if (start) begin
        since   <= 1;
        pending <= 64'(a) * 64'(b);
      end
    end else if (since < 33) begin
      since <= since + 1;
      if (since == 32) exp_product <= pending;
    end else begin
      since <= -1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(since >= 1 && since <= 32));
    check("done", 64'(done), 64'(since == 33));
    if (since < 0 || since == 33) check("product", product, exp_product);
    if (done) $display("op complete: product=%h model=%h", product, exp_product);
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Called right after a negedge while idle; returns at a negedge in idle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [63:0] lit, input string name);
    int busy_cycles;
    int lat;
    busy_cycles = 0;
    lat = 0;
    start = 1'b1;
    a = ta;
    b = tb_v;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (busy) busy_cycles++;
      if (done) lat = i;
      else @(negedge clk);
    end
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy_cycles), 64'd32);
    check({name, "_product"}, product, lit);
    check({name, "_model"}, exp_product, lit);
    $display("%s: a=%h b=%h product=%h latency=%0d", name, ta, tb_v, product, lat);
    @(negedge clk);
  endtask

  initial begin
    int done_cnt;
    int prev;
    logic [63:0] seen_product;

    // Reset state
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed operands; the first start coincides with reset release.
    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "small");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    run_op(32'h0, 32'h1234_5678, 64'h0, "zero");
    run_op(32'hAAAA_AAAA, 32'h1, 64'h0000_0000_AAAA_AAAA, "identity");

    // Start while busy is ignored
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    seen_product = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        done_cnt++;
        seen_product = product;
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 64'(done_cnt), 64'd1);
    check("busy_start_product", seen_product, 64'd63);
    $display("start-while-busy: done pulses=%0d product=%h", done_cnt, seen_product);

    // Asynchronous reset in the middle of a run
    start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", product, 64'd0);
    $display("mid-run reset: busy=%b done=%b product=%h", busy, done, product);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd6, 32'd7, 64'd42, "after_reset");

    // Back-to-back with start held high
    start = 1'b1; a = 32'd10; b = 32'd11;
    prev = -1;
    done_cnt = 0;
    for (int i = 0; i < 34 * 4 + 5; i++) begin
      @(negedge clk);
      if (done) begin
        if (prev >= 0) check("b2b_period", 64'(i - prev), 64'd34);
        check("b2b_product", product, 64'd110);
        prev = i;
        done_cnt++;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(done_cnt), 64'd4);
    $display("back-to-back: done pulses=%0d", done_cnt);
    repeat (40) @(negedge clk);

    // Randomized traffic, occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = pick();
      b = pick();
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
